// File: rtl/moore_seq_detect_pkg.sv
// Shared types and helpers for the parametrised Moore serial pattern detector.
// Pulled into the detector and its prefix matcher with a package import.
package moore_seq_detect_pkg;

    localparam int N_MAX = 16;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_SHIFT = 2'd2
    } act_e;

    function automatic int state_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational longest-prefix matcher: finds the largest k such that the
// newest k valid history bits equal the first k pattern bits.
module seq_prefix_match
    import moore_seq_detect_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = state_w(N)
) (
    input  logic [N-1:0]  hist,
    input  logic [SW-1:0] len,
    input  logic [N-1:0]  pat,
    output logic [SW-1:0] k
);

    logic ok;

    // hist[0] is the newest bit; pat[N-1] is the first expected bit.
    always_comb begin
        k  = '0;
        ok = 1'b0;
        for (int j = 1; j <= N; j++) begin
            ok = (j <= int'(len));
            for (int i = 0; i < j; i++) begin
                if (hist[j-1-i] != pat[N-1-i]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                k = SW'(j);
            end
        end
    end

endmodule

// File: rtl/moore_seq_detect.sv
// Moore serial pattern detector with runtime-loadable pattern, optional
// overlapping detection and a saturating match counter.
module moore_seq_detect
    import moore_seq_detect_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int CNT_W = 8,
    localparam int SW    = state_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             en,
    input  logic             load,
    input  logic [N-1:0]     pattern,
    input  logic             overlap,
    output logic [SW-1:0]    y,
    output logic             match,
    output logic [CNT_W-1:0] count
);

    logic [N-1:0]     pat_q,   pat_d;
    logic [N-1:0]     hist_q,  hist_d;
    logic [SW-1:0]    len_q,   len_d;
    logic [SW-1:0]    y_q,     y_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] count_q, count_d;

    act_e          act;
    logic          restart;
    logic [N-1:0]  hist_sh;
    logic [SW-1:0] len_sh;
    logic [SW-1:0] k_next;
    logic          full_next;

    always_comb begin
        if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_SHIFT;
        end else begin
            act = ACT_NONE;
        end
    end

    // Non-overlapping mode: the bit after a full match starts a fresh history.
    always_comb begin
        restart = (y_q == SW'(N)) && !overlap;
        if (restart) begin
            hist_sh = {{(N-1){1'b0}}, b};
            len_sh  = SW'(1);
        end else begin
            hist_sh = {hist_q[N-2:0], b};
            len_sh  = (len_q == SW'(N)) ? len_q : len_q + 1'b1;
        end
    end

    seq_prefix_match #(
        .N (N)
    ) u_match (
        .hist (hist_sh),
        .len  (len_sh),
        .pat  (pat_q),
        .k    (k_next)
    );

    assign full_next = (k_next == SW'(N));

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        len_d   = len_q;
        y_d     = y_q;
        match_d = match_q;
        count_d = count_q;
        unique case (act)
            ACT_LOAD: begin
                pat_d   = pattern;
                hist_d  = '0;
                len_d   = '0;
                y_d     = '0;
                match_d = 1'b0;
                count_d = '0;
            end
            ACT_SHIFT: begin
                hist_d  = hist_sh;
                len_d   = len_sh;
                y_d     = k_next;
                match_d = full_next;
                if (full_next && (count_q != {CNT_W{1'b1}})) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            hist_q  <= '0;
            len_q   <= '0;
            y_q     <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            len_q   <= len_d;
            y_q     <= y_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign y     = y_q;
    assign match = match_q;
    assign count = count_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Directed bench for moore_seq_detect: a 4-bit instance and a 2-bit
// instance with a 2-bit counter for saturation.
module tb_moore_seq_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       b = 1'b0, en = 1'b0, load = 1'b0, overlap = 1'b0;
    logic [3:0] pattern = '0;
    logic [2:0] y;
    logic       match;
    logic [7:0] count;

    logic       b2 = 1'b0, en2 = 1'b0, load2 = 1'b0, ov2 = 1'b0;
    logic [1:0] pat2 = '0;
    logic [1:0] y2;
    logic       match2;
    logic [1:0] count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    moore_seq_detect #(.N(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .b       (b),
        .en      (en),
        .load    (load),
        .pattern (pattern),
        .overlap (overlap),
        .y       (y),
        .match   (match),
        .count   (count)
    );

    moore_seq_detect #(.N(2), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .b       (b2),
        .en      (en2),
        .load    (load2),
        .pattern (pat2),
        .overlap (ov2),
        .y       (y2),
        .match   (match2),
        .count   (count2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int ey, input int ec);
        check({tag, ".y"}, int'(y), ey);
        check({tag, ".match"}, int'(match), (ey == 4) ? 1 : 0);
        check({tag, ".count"}, int'(count), ec);
    endtask

    task automatic shift_a(input string tag, input logic bv,
                           input int ey, input int ec);
        en = 1'b1;
        b  = bv;
        step();
        en = 1'b0;
        chk_a(tag, ey, ec);
    endtask

    task automatic load_a(input logic [3:0] p);
        load    = 1'b1;
        pattern = p;
        step();
        load = 1'b0;
    endtask

    initial begin
        static logic [6:0] stream = 7'b1011011;
        static int ov_y[7] = '{1, 2, 3, 4, 2, 3, 4};
        static int ov_c[7] = '{0, 0, 0, 1, 1, 1, 2};
        static int no_y[7] = '{1, 2, 3, 4, 0, 1, 1};
        static int no_c[7] = '{0, 0, 0, 1, 1, 1, 1};
        static int sat_y[6] = '{1, 2, 2, 2, 2, 2};
        static int sat_c[6] = '{0, 1, 2, 3, 3, 3};
        static logic [3:0] s2 = 4'b0110;

        step();
        step();
        chk_a("reset", 0, 0);
        check("reset.y2", int'(y2), 0);
        check("reset.count2", int'(count2), 0);
        rst = 1'b0;

        load_a(4'b1011);
        chk_a("load1", 0, 0);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++)
            shift_a($sformatf("ov%0d", i), stream[6-i], ov_y[i], ov_c[i]);

        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("hold%0d", i), 4, 2);
        end

        load_a(4'b1011);
        overlap = 1'b0;
        for (int i = 0; i < 7; i++)
            shift_a($sformatf("nov%0d", i), stream[6-i], no_y[i], no_c[i]);

        en = 1'b1;
        b  = 1'b0;
        load_a(4'b0110);
        en = 1'b0;
        chk_a("ldprio", 0, 0);
        for (int i = 0; i < 4; i++)
            shift_a($sformatf("lp%0d", i), s2[3-i], i + 1, (i == 3) ? 1 : 0);

        load_a(4'b1011);
        overlap = 1'b1;
        shift_a("mid0", 1'b1, 1, 0);
        shift_a("mid1", 1'b0, 2, 0);
        shift_a("mid2", 1'b1, 3, 0);
        rst     = 1'b1;
        load    = 1'b1;
        en      = 1'b1;
        b       = 1'b1;
        pattern = 4'b1111;
        step();
        rst  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
        chk_a("rstmid", 0, 0);
        for (int i = 0; i < 4; i++)
            shift_a($sformatf("zpat%0d", i), 1'b0, i + 1, (i == 3) ? 1 : 0);

        load2 = 1'b1;
        pat2  = 2'b11;
        step();
        load2 = 1'b0;
        ov2   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            en2 = 1'b1;
            b2  = 1'b1;
            step();
            en2 = 1'b0;
            check($sformatf("sat%0d.y", i), int'(y2), sat_y[i]);
            check($sformatf("sat%0d.match", i), int'(match2),
                  (sat_y[i] == 2) ? 1 : 0);
            check($sformatf("sat%0d.count", i), int'(count2), sat_c[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/moore_seq_detect.md
# moore_seq_detect

Parametrised Moore-machine serial pattern detector, the next generation of the team's fixed 3-bit-state serial FSM. It accepts one serial bit per enabled clock and tracks how many leading bits of a runtime-loadable N-bit pattern have been matched. That count is exposed as a registered Moore state output, alongside a match flag and a saturating match counter. It sits directly behind a serial bit source and feeds status/counter logic.

## Interface
- N, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, match counter width in bits; legal range 1..32.
- SW, $clog2(N+1), derived state width; not overridable.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high; overrides every other input.
- b  in  1  serial data bit; sampled only when en=1.
- en  in  1  bit-accept strobe; when en=0, all state holds.
- load  in  1  loads the pattern input into the pattern register.
- pattern  in  N  new pattern; pattern[N-1] is the first bit expected.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on each accepted bit.
- y  out  SW  Moore state: number of pattern-prefix bits currently matched, 0..N.
- match  out  1  registered; equals (y == N).
- count  out  CNT_W  number of matches since reset or load; saturating.

## Operation
- Reset (rst=1 at an edge) sets: pattern register = 0, y = 0, match = 0, count = 0, history cleared.
- Input priority at each edge, highest first: rst, then load, then en.
- load=1 (no rst):
  - pattern register = pattern; y = 0; count = 0; history cleared.
  - A coincident en/b is discarded.
- en=1 (no rst, no load) accepts bit b into a history of accepted bits.
- The history counts only bits accepted since the last restart. Restart events:
  - reset;
  - load;
  - acceptance of a bit while y == N and overlap = 0. That bit becomes the first bit after the restart.
- Next y = largest k in 0..N such that the last k history bits equal pattern[N-1 -: k].
- Overlap = 1: after a full match, history continues, so suffixes of a match may seed the next one (KMP semantics).
- count increments on each edge where next y == N, and saturates at all-ones.
- Neither a changed pattern input nor a change of overlap affects state until load or the next accepted bit, respectively.
- Moore property: y and match are functions of registered state only, never of the current b.

## Timing
- Latency:
  - y reflects bit b one cycle after the edge that accepted it.
  - match asserts in the same cycle that y reaches N.
  - count updates on the same edge.
- match stays high while en=0; it drops on the next accepted bit unless that bit completes another match.
- Back-to-back matches with overlap=1 may assert match on consecutive accepted bits.
- load and rst take effect in one cycle; outputs read 0 the following cycle.
- No handshake; en may toggle every cycle.

## Structure
- Package moore_seq_detect_pkg holds:
  - N_MAX = 16;
  - a state-width function returning clog2(N+1);
  - the typedef for the priority-decoded control action (NONE, LOAD, SHIFT).
- Sub-module seq_prefix_match is combinational. It takes the history, the valid-length count and the pattern, and returns the next k.
- The top level holds the registers, priority logic, restart logic and saturating counter.

## Test plan
- Overlap: N=4, load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 -> y = 1,2,3,4,2,3,4; match high twice; count=2.
- Non-overlap: same stream, overlap=0 -> y = 1,2,3,4,0,1,1; count=1.
- Hold: en=0 for 3 cycles while y=4 -> y=4 and match=1 throughout; count unchanged.
- Saturation: N=2, CNT_W=2, pattern 2'b11, overlap=1, stream of six 1s -> count = 0,1,2,3,3,3.
- Load priority: load 4'b0110 with en=1, b=0 at the same edge -> y=0, count=0, bit ignored; next stream 0,1,1,0 -> count=1.
- Reset mid-stream: rst with load=1 and en=1 after y=3 -> y=0, match=0, count=0, pattern register=0 next cycle.
